// File: rtl/fp_align_add.sv
// fp_align_add
//   Two-stage pipelined FP32 add/sub front end for the Conv3X3 accumulator.
//   The stage-1 logic works out which operand has the larger magnitude and
//   right-shifts the smaller mantissa to line it up with the larger one.
//   Stage 2 adds or subtracts the two magnitudes and registers a 25-bit
//   unnormalized result for the priority-encoder normalizer.
//   Denormals are flushed to zero. Inf/NaN operands raise Special, and the
//   magnitude is forced to zero in that case.
//
//   Optional feature: define FP_ADD_STICKY_EN to jam every bit shifted out of
//   the smaller mantissa into aligned[0]. Left undefined, those bits are
//   simply dropped (truncation).
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   InValid   operand pair valid
//   InReady   operands accepted this cycle (combinational)
//   OpA, OpB  IEEE-754 single operands
//   OutValid  result fields valid
//   OutReady  downstream consumes this cycle
//   SumMag    magnitude sum, bit MANT_W = carry, bit MANT_W-1 = hidden bit
//   ExpOut    exponent of the larger-magnitude operand
//   SignOut   result sign (0 when SumMag is zero)
//   Special   an operand was Inf/NaN; data fields are don't-care

module fp_align_add #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       OpA,
  input  logic [31:0]       OpB,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [MANT_W:0]   SumMag,
  output logic [EXP_W-1:0]  ExpOut,
  output logic              SignOut,
  output logic              Special
);

  localparam int FRAC_W = MANT_W - 1;
  localparam int SIGN_B = FRAC_W + EXP_W;

  // Elastic handshake: a stage loads when it is empty or when its contents move on.
  logic valid1, valid2;
  logic s1Ld, s2Ld;

  assign s2Ld     = !valid2 || OutReady;
  assign s1Ld     = !valid1 || s2Ld;
  assign InReady  = s1Ld;
  assign OutValid = valid2;

  // Stage 1: unpack, order by magnitude, align.
  logic [EXP_W-1:0]  expA, expB, expL, expS, expDiff;
  logic [FRAC_W-1:0] fracA, fracB;
  logic [MANT_W-1:0] mantA, mantB, mantL, mantS, shifted, alignedNext;
  logic              signA, signB, signL, swapAB, specialNext;

  assign expA  = OpA[FRAC_W +: EXP_W];
  assign expB  = OpB[FRAC_W +: EXP_W];
  assign fracA = OpA[FRAC_W-1:0];
  assign fracB = OpB[FRAC_W-1:0];
  assign signA = OpA[SIGN_B];
  assign signB = OpB[SIGN_B];

  // A zero exponent covers both true zero and denormals, and both flush to zero.
  assign mantA = (expA == '0) ? '0 : {1'b1, fracA};
  assign mantB = (expB == '0) ? '0 : {1'b1, fracB};

  // {exp,frac} orders magnitudes. On a tie A stays the larger operand.
  assign swapAB = {expB, fracB} > {expA, fracA};
  assign expL   = swapAB ? expB  : expA;
  assign expS   = swapAB ? expA  : expB;
  assign mantL  = swapAB ? mantB : mantA;
  assign mantS  = swapAB ? mantA : mantB;
  assign signL  = swapAB ? signB : signA;

  assign expDiff = expL - expS;

  // A shift amount at or beyond the mantissa width already yields zero,
  // so large exponent differences need no separate clamp.
  assign shifted = mantS >> expDiff;

`ifdef FP_ADD_STICKY_EN
  // The mask covers the bits that fall off the bottom. It becomes all ones when the shift
  // is at least the mantissa width.
  logic sticky;
  assign sticky      = |(mantS & ~({MANT_W{1'b1}} << expDiff));
  assign alignedNext = shifted | {{(MANT_W-1){1'b0}}, sticky};
`else
  assign alignedNext = shifted;
`endif

  assign specialNext = (expA == '1) || (expB == '1);

  logic [MANT_W-1:0] mantL1, aligned1;
  logic [EXP_W-1:0]  expL1;
  logic              signL1, opSub1, special1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1   <= 1'b0;
      mantL1   <= '0;
      aligned1 <= '0;
      expL1    <= '0;
      signL1   <= 1'b0;
      opSub1   <= 1'b0;
      special1 <= 1'b0;
    end else if (s1Ld) begin
      valid1 <= InValid;
      if (InValid) begin
        mantL1   <= mantL;
        aligned1 <= alignedNext;
        expL1    <= expL;
        signL1   <= signL;
        opSub1   <= signA ^ signB;
        special1 <= specialNext;
      end
    end
  end

  // Stage 2: magnitude add/sub. The operand swap keeps the subtraction non-negative.
  logic [MANT_W:0] sumRaw, sumNext;
  logic            signNext;

  assign sumRaw   = opSub1 ? ({1'b0, mantL1} - {1'b0, aligned1})
                           : ({1'b0, mantL1} + {1'b0, aligned1});
  assign sumNext  = special1 ? '0 : sumRaw;
  assign signNext = (sumNext != '0) && signL1;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid2  <= 1'b0;
      SumMag  <= '0;
      ExpOut  <= '0;
      SignOut <= 1'b0;
      Special <= 1'b0;
    end else if (s2Ld) begin
      valid2 <= valid1;
      if (valid1) begin
        SumMag  <= sumNext;
        ExpOut  <= expL1;
        SignOut <= signNext;
        Special <= special1;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid, InReady;
  logic [31:0] OpA, OpB;
  logic        OutValid, OutReady;
  logic [24:0] SumMag;
  logic [7:0]  ExpOut;
  logic        SignOut, Special;

  fp_align_add dut (
    .clk(clk), .rst(rst),
    .InValid(InValid), .InReady(InReady),
    .OpA(OpA), .OpB(OpB),
    .OutValid(OutValid), .OutReady(OutReady),
    .SumMag(SumMag), .ExpOut(ExpOut), .SignOut(SignOut), .Special(Special)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef FP_ADD_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  typedef struct packed {
    logic [24:0] sum;
    logic [7:0]  exp;
    logic        sign;
    logic        special;
  } res_t;

  res_t expQ[$];

  // Reference: real-number view of the operation using integer magnitudes.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [31:0] l, s;
    longint      mantL, mantS, aligned, lost, sum, scale;
    int          d;
    if (b[30:0] > a[30:0]) begin l = b; s = a; end
    else begin l = a; s = b; end
    mantL = (l[30:23] == 8'd0) ? 64'd0 : (64'd8388608 + longint'(l[22:0]));
    mantS = (s[30:23] == 8'd0) ? 64'd0 : (64'd8388608 + longint'(s[22:0]));
    d = int'(l[30:23]) - int'(s[30:23]);
    if (d >= 24) begin
      aligned = 0;
      lost    = mantS;
    end else begin
      scale   = longint'(1) << d;
      aligned = mantS / scale;
      lost    = mantS - aligned * scale;
    end
    if (STICKY_EN && lost != 0) aligned = aligned | 64'd1;
    sum = (a[31] ^ b[31]) ? (mantL - aligned) : (mantL + aligned);
    r.special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    if (r.special) sum = 0;
    r.sum  = 25'(sum);
    r.exp  = l[30:23];
    r.sign = (sum == 0) ? 1'b0 : l[31];
    return r;
  endfunction

  function automatic logic [31:0] randOp();
    logic [7:0] e;
    int unsigned k;
    k = $urandom_range(0, 19);
    if (k == 0)      e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else             e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  localparam logic [31:0] DIR_A [8] = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F800000,
                                        32'h00000000, 32'h3F800000, 32'hC0400000, 32'h80000000};
  localparam logic [31:0] DIR_B [8] = '{32'h3F800000, 32'hBF000000, 32'hBF800000, 32'hBF800000,
                                        32'h00000000, 32'h30800000, 32'h3FC00000, 32'h80000000};
  localparam logic [24:0] DIR_S [8] = '{25'h1000000, 25'h0400000, 25'h0400000, 25'h0000000,
                                        25'h0000000, STICKY_EN ? 25'h0800001 : 25'h0800000,
                                        25'h0600000, 25'h0000000};
  localparam logic [7:0]  DIR_E [8] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd0, 8'd127, 8'd128, 8'd0};
  localparam logic        DIR_G [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic test_reset();
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    checks += 6;
    if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b want 0", OutValid); end
    if (InReady !== 1'b1)  begin errors++; $display("FAIL reset_inready got %b want 1", InReady); end
    if (SumMag !== 25'h0)  begin errors++; $display("FAIL reset_summag got %h want 0", SumMag); end
    if (ExpOut !== 8'h0)   begin errors++; $display("FAIL reset_expout got %h want 0", ExpOut); end
    if (SignOut !== 1'b0)  begin errors++; $display("FAIL reset_signout got %b want 0", SignOut); end
    if (Special !== 1'b0)  begin errors++; $display("FAIL reset_special got %b want 0", Special); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      OutReady = 1'b1; InValid = 1'b1; OpA = DIR_A[i]; OpB = DIR_B[i];
      @(posedge clk);
      @(negedge clk); InValid = 1'b0; #1;
      checks++;
      if (OutValid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, OutValid); end
      @(posedge clk);
      @(negedge clk); #1;
      checks += 5;
      if (OutValid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %b want 1", i, OutValid); end
      if (SumMag !== DIR_S[i]) begin errors++; $display("FAIL dir%0d_summag got %h want %h", i, SumMag, DIR_S[i]); end
      if (ExpOut !== DIR_E[i]) begin errors++; $display("FAIL dir%0d_expout got %0d want %0d", i, ExpOut, DIR_E[i]); end
      if (SignOut !== DIR_G[i]) begin errors++; $display("FAIL dir%0d_sign got %b want %b", i, SignOut, DIR_G[i]); end
      if (Special !== 1'b0) begin errors++; $display("FAIL dir%0d_special got %b want 0", i, Special); end
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] bpA [3] = '{32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] bpB [3] = '{32'h3F800000, 32'h3F800000, 32'hBF000000};
    int   acc = 0;
    int   got = 0;
    res_t e;
    expQ.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      OutReady = 1'b0;
      InValid  = (acc < 3);
      OpA = bpA[acc % 3]; OpB = bpB[acc % 3];
      #1;
      if (c >= 2) begin
        e = expQ[0];
        checks += 3;
        if (InReady !== 1'b0) begin errors++; $display("FAIL bp_inready_c%0d got %b want 0", c, InReady); end
        if (OutValid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_c%0d got %b want 1", c, OutValid); end
        if (SumMag !== e.sum) begin errors++; $display("FAIL bp_hold_summag_c%0d got %h want %h", c, SumMag, e.sum); end
      end
      if (InValid && InReady) begin expQ.push_back(model(OpA, OpB)); acc++; end
    end
    checks++;
    if (acc != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      OutReady = 1'b1;
      InValid  = (acc < 3);
      OpA = bpA[acc % 3]; OpB = bpB[acc % 3];
      #1;
      if (c < 3) begin
        checks++;
        if (OutValid !== 1'b1) begin errors++; $display("FAIL bp_bubble_c%0d got %b want 1", c, OutValid); end
      end
      if (OutValid && OutReady) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL bp_extra_output got %h want none", SumMag);
        end else begin
          e = expQ.pop_front();
          got++;
          if (SumMag !== e.sum || ExpOut !== e.exp || SignOut !== e.sign) begin
            errors++;
            $display("FAIL bp_result%0d got %h/%0d/%b want %h/%0d/%b", got, SumMag, ExpOut, SignOut, e.sum, e.exp, e.sign);
          end
        end
      end
      if (InValid && InReady) begin expQ.push_back(model(OpA, OpB)); acc++; end
    end
    checks++;
    if (got != 3 || acc != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got); end
    InValid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] spA [2] = '{32'h7F800000, 32'h3F800000};
    logic [31:0] spB [2] = '{32'h3F800000, 32'hFFC00000};
    @(negedge clk);
    OutReady = 1'b0; InValid = 1'b1; OpA = 32'h3F800000; OpB = 32'h3F800000;
    repeat (2) @(posedge clk);
    @(negedge clk); InValid = 1'b0; #1;
    checks++;
    if (OutValid !== 1'b1 || InReady !== 1'b0) begin
      errors++; $display("FAIL mid_full got %b/%b want 1/0", OutValid, InReady);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; OutReady = 1'b1; #1;
    checks += 3;
    if (OutValid !== 1'b0) begin errors++; $display("FAIL mid_outvalid got %b want 0", OutValid); end
    if (InReady !== 1'b1)  begin errors++; $display("FAIL mid_inready got %b want 1", InReady); end
    if (SumMag !== 25'h0)  begin errors++; $display("FAIL mid_summag got %h want 0", SumMag); end
    expQ.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      InValid = 1'b1; OpA = spA[i]; OpB = spB[i];
      @(posedge clk);
      @(negedge clk); InValid = 1'b0;
      @(posedge clk);
      @(negedge clk); #1;
      checks += 2;
      if (OutValid !== 1'b1 || Special !== 1'b1) begin
        errors++; $display("FAIL special%0d got valid %b special %b want 1/1", i, OutValid, Special);
      end
      if (SumMag !== 25'h0) begin errors++; $display("FAIL special%0d_summag got %h want 0", i, SumMag); end
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    res_t        e;
    logic [31:0] t;
    int          drain;
    expQ.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      InValid  = ($urandom_range(0, 9) < 7);
      OutReady = ($urandom_range(0, 9) < 7);
      OpA = randOp();
      t   = randOp();
      case ($urandom_range(0, 3))
        0:       OpB = {~OpA[31], OpA[30:0]};
        1:       OpB = {t[31], OpA[30:23], t[22:0]};
        default: OpB = t;
      endcase
      #1;
      checks++;
      if (InReady !== (expQ.size() < 2 || OutReady)) begin
        errors++; $display("FAIL rnd_inready c%0d got %b inflight %0d", c, InReady, expQ.size());
      end
      if (OutValid && OutReady) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("FAIL rnd_extra_output c%0d got %h want none", c, SumMag);
        end else begin
          e = expQ.pop_front();
          if (e.special) begin
            if (Special !== 1'b1 || SumMag !== 25'h0) begin
              errors++; $display("FAIL rnd_special c%0d got %b/%h want 1/0", c, Special, SumMag);
            end
          end else if (Special !== 1'b0 || SumMag !== e.sum || ExpOut !== e.exp || SignOut !== e.sign) begin
            errors++;
            $display("FAIL rnd_result c%0d got %b %h %0d %b want 0 %h %0d %b",
                     c, Special, SumMag, ExpOut, SignOut, e.sum, e.exp, e.sign);
          end
        end
      end
      if (InValid && InReady) expQ.push_back(model(OpA, OpB));
    end
    drain = 0;
    while (expQ.size() != 0 && drain < 10) begin
      @(negedge clk);
      InValid = 1'b0; OutReady = 1'b1; #1;
      if (OutValid) begin
        e = expQ.pop_front();
        checks++;
        if (SumMag !== e.sum || Special !== e.special) begin
          errors++; $display("FAIL rnd_drain got %h want %h", SumMag, e.sum);
        end
      end
      drain++;
    end
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", expQ.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b1; OpA = '0; OpB = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
